// File: rtl/hazard_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit_if
//  Description : Signal bundle between the pipeline datapath and the hazard
//                unit. The pipeline side (master) presents the decode-stage
//                operands, the load in ID/EX, branch resolution and memory
//                readiness. The hazard unit (slave) answers with stall,
//                register-enable and flush controls plus status/statistics.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals
//    ifid_opcode  [5:0]  opcode of the instruction being decoded
//    ifid_rs/rt   [4:0]  source registers of the IF/ID instruction
//    idex_memread        ID/EX instruction is a load
//    idex_rt      [4:0]  destination register of that load
//    branch_taken        branch resolved taken in the M stage
//    mem_busy            memory not ready
//    stall               forces a bubble into decode
//    pc_write            PC register enable
//    ifid_write          IF/ID register enable
//    flush_ifid/idex/exmem  pipeline register flushes
//    state        [1:0]  hazard FSM state (RUN/LDSTALL/MEMWAIT/FLUSH)
//    mem_timeout         sticky: memory busy for 255 consecutive cycles
//    stall_cycles [15:0] stall statistics (zero unless stats are built)
//    flush_count  [7:0]  flush statistics (zero unless stats are built)
// ============================================================================
interface hazard_unit_if;
    logic [5:0]  ifid_opcode;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic        idex_memread;
    logic [4:0]  idex_rt;
    logic        branch_taken;
    logic        mem_busy;

    logic        stall;
    logic        pc_write;
    logic        ifid_write;
    logic        flush_ifid;
    logic        flush_idex;
    logic        flush_exmem;
    logic [1:0]  state;
    logic        mem_timeout;
    logic [15:0] stall_cycles;
    logic [7:0]  flush_count;

    modport master (
        output ifid_opcode, ifid_rs, ifid_rt, idex_memread, idex_rt,
               branch_taken, mem_busy,
        input  stall, pc_write, ifid_write, flush_ifid, flush_idex,
               flush_exmem, state, mem_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  ifid_opcode, ifid_rs, ifid_rt, idex_memread, idex_rt,
               branch_taken, mem_busy,
        output stall, pc_write, ifid_write, flush_ifid, flush_idex,
               flush_exmem, state, mem_timeout, stall_cycles, flush_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : Pipeline hazard controller. Detects load-use hazards in
//                decode, freezes the front end while memory is busy, and
//                flushes the younger stages when a branch resolves taken.
//                A sticky timeout flags 255 consecutive memory-busy cycles.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in   single clock, all state updates on the rising edge
//    reset  in   asynchronous, active-high; clears all state immediately
//    bus    slave modport of hazard_unit_if (see that file for signals)
//
//  Build option
//    HAZARD_STATS_EN  when defined, saturating stall_cycles / flush_count
//                     counters are built; otherwise both read constant 0.
// ============================================================================
module hazard_unit (
    input  wire logic     clk,
    input  wire logic     reset,
    hazard_unit_if.slave  bus
);

    // Opcodes whose rt field is a source operand
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_STB   = 6'h28;
    localparam logic [5:0] c_OP_STW   = 6'h2B;

    localparam logic [7:0] c_BUSY_MAX = 8'hFF;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_LDSTALL = 2'd1,
        S_MEMWAIT = 2'd2,
        S_FLUSH   = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_uses_rt;
    logic       w_load_use;
    logic       w_lu_window;
    logic       w_stall;
    logic [7:0] r_busy_cnt;
    logic       r_mem_timeout;

    // ------------------------------------------------------------------
    // Load-use detection
    // ------------------------------------------------------------------
    always_comb begin
        w_uses_rt = 1'b0;
        case (bus.ifid_opcode)
            c_OP_RTYPE, c_OP_STB, c_OP_STW, c_OP_BEQ: w_uses_rt = 1'b1;
            default:                                  w_uses_rt = 1'b0;
        endcase
    end

    assign w_load_use = bus.idex_memread
                     && (bus.idex_rt != 5'd0)
                     && ((bus.idex_rt == bus.ifid_rs)
                         || (w_uses_rt && (bus.idex_rt == bus.ifid_rt)));

    // load_use is only meaningful when ID/EX and IF/ID hold real
    // instructions. In LDSTALL ID/EX is the inserted bubble and in FLUSH
    // IF/ID is a flushed bubble, so both mask it. The cycle in which
    // mem_busy drops out of MEMWAIT is the first cycle the frozen pipeline
    // moves again, so the hazard is evaluated there exactly as in RUN.
    assign w_lu_window = (r_state == S_RUN) || (r_state == S_MEMWAIT);

    // ------------------------------------------------------------------
    // FSM: next state and combinational controls
    // ------------------------------------------------------------------
    always_comb begin
        w_stall     = 1'b0;
        w_state_nxt = S_RUN;

        if (!reset) begin
            w_stall = bus.mem_busy
                   || (w_lu_window && w_load_use && !bus.branch_taken);
        end

        if (bus.branch_taken) begin
            w_state_nxt = S_FLUSH;
        end else if (bus.mem_busy) begin
            w_state_nxt = S_MEMWAIT;
        end else if (w_lu_window && w_load_use) begin
            w_state_nxt = S_LDSTALL;
        end else begin
            w_state_nxt = S_RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The branch target load must reach the PC even during a stall.
    assign bus.stall       = w_stall;
    assign bus.pc_write    = bus.branch_taken || !w_stall;
    assign bus.ifid_write  = !w_stall;
    assign bus.flush_ifid  = bus.branch_taken;
    assign bus.flush_idex  = bus.branch_taken;
    assign bus.flush_exmem = bus.branch_taken;
    assign bus.state       = r_state;

    // ------------------------------------------------------------------
    // Memory-busy watchdog: counts consecutive busy cycles, saturating.
    // The timeout is raised on the edge that brings the count to 255.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy_cnt    <= 8'd0;
            r_mem_timeout <= 1'b0;
        end else if (bus.mem_busy) begin
            if (r_busy_cnt != c_BUSY_MAX) begin
                r_busy_cnt <= r_busy_cnt + 8'd1;
            end
            if (r_busy_cnt >= (c_BUSY_MAX - 8'd1)) begin
                r_mem_timeout <= 1'b1;
            end
        end else begin
            r_busy_cnt <= 8'd0;
        end
    end

    assign bus.mem_timeout = r_mem_timeout;

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
    logic [15:0] r_stall_cycles;
    logic [7:0]  r_flush_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= 16'd0;
            r_flush_count  <= 8'd0;
        end else begin
            if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (bus.branch_taken && (r_flush_count != 8'hFF)) begin
                r_flush_count <= r_flush_count + 8'd1;
            end
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_count  = r_flush_count;
`else
    assign bus.stall_cycles = 16'd0;
    assign bus.flush_count  = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_unit
//  Description : Self-checking bench for hazard_unit: directed vector table,
//                hand-written multi-cycle sequences and randomized stimulus
//                checked against a rule-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_unit;

    localparam logic [5:0] c_RT  = 6'h00;
    localparam logic [5:0] c_BEQ = 6'h04;
    localparam logic [5:0] c_ADI = 6'h08;
    localparam logic [5:0] c_LDW = 6'h23;
    localparam logic [5:0] c_STB = 6'h28;
    localparam logic [5:0] c_STW = 6'h2B;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_unit_if bus ();

    hazard_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model: state numbers RUN=0 LDSTALL=1 MEMWAIT=2 FLUSH=3
    int m_state;
    int m_run;
    int m_to;
    int m_sc;
    int m_fc;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       mr;
        logic [4:0] irt;
        logic       bt;
        logic       busy;
        logic       e_stall;
        logic       e_pcw;
        logic       e_ifw;
        logic       e_fl;
        int         e_next;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic mr, input logic [4:0] irt, input logic bt, input logic busy);
        bus.ifid_opcode  = op;
        bus.ifid_rs      = rs;
        bus.ifid_rt      = rt;
        bus.idex_memread = mr;
        bus.idex_rt      = irt;
        bus.branch_taken = bt;
        bus.mem_busy     = busy;
    endtask

    function automatic int model_load_use();
        int rt_src;
        rt_src = (bus.ifid_opcode == c_RT || bus.ifid_opcode == c_BEQ ||
                  bus.ifid_opcode == c_STB || bus.ifid_opcode == c_STW) ? 1 : 0;
        if (bus.idex_memread !== 1'b1 || bus.idex_rt == 5'd0) return 0;
        if (bus.idex_rt == bus.ifid_rs) return 1;
        if (rt_src == 1 && bus.idex_rt == bus.ifid_rt) return 1;
        return 0;
    endfunction

    // Reset: asserted mid-cycle; outputs checked before the next edge.
    task automatic do_reset();
        #1;
        reset = 1'b1;
        #1;
        check("rst_state", int'(bus.state), 0);
        check("rst_timeout", int'(bus.mem_timeout), 0);
        check("rst_stall", int'(bus.stall), 0);
        check("rst_pcw", int'(bus.pc_write), 1);
        check("rst_ifw", int'(bus.ifid_write), 1);
        check("rst_flush", int'({bus.flush_ifid, bus.flush_idex, bus.flush_exmem}),
              bus.branch_taken ? 7 : 0);
        check("rst_stats", int'(bus.stall_cycles) + int'(bus.flush_count), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_state = 0; m_run = 0; m_to = 0; m_sc = 0; m_fc = 0;
    endtask

    // One cycle: inputs already driven at posedge+1. Checks combinational
    // outputs, clocks, advances the model, checks registered outputs.
    task automatic step();
        int lu, e_stall, bt, busy, nxt, e_sc, e_fc;
        #2;
        bt   = int'(bus.branch_taken);
        busy = int'(bus.mem_busy);
        lu   = model_load_use();
        e_stall = (busy == 1 || ((m_state == 0 || m_state == 2) && lu == 1 && bt == 0)) ? 1 : 0;
        check("stall", int'(bus.stall), e_stall);
        check("pc_write", int'(bus.pc_write), (bt == 1) ? 1 : 1 - e_stall);
        check("ifid_write", int'(bus.ifid_write), 1 - e_stall);
        check("flushes", int'({bus.flush_ifid, bus.flush_idex, bus.flush_exmem}), bt * 7);
        if (bt == 1)                                          nxt = 3;
        else if (busy == 1)                                   nxt = 2;
        else if ((m_state == 0 || m_state == 2) && lu == 1)   nxt = 1;
        else                                                  nxt = 0;
        @(posedge clk);
        m_state = nxt;
        m_run   = (busy == 1) ? ((m_run < 255) ? m_run + 1 : 255) : 0;
        if (m_run == 255) m_to = 1;
        if (e_stall == 1 && m_sc < 65535) m_sc++;
        if (bt == 1 && m_fc < 255) m_fc++;
        #1;
`ifdef HAZARD_STATS_EN
        e_sc = m_sc; e_fc = m_fc;
`else
        e_sc = 0; e_fc = 0;
`endif
        check("state", int'(bus.state), m_state);
        check("mem_timeout", int'(bus.mem_timeout), m_to);
        check("stall_cycles", int'(bus.stall_cycles), e_sc);
        check("flush_count", int'(bus.flush_count), e_fc);
    endtask

    function automatic vec_t mk(input string n, input logic [5:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic mr, input logic [4:0] irt,
                                input logic bt, input logic busy, input logic es,
                                input logic ep, input logic ei, input logic ef, input int en);
        vec_t v;
        v.name = n; v.op = op; v.rs = rs; v.rt = rt; v.mr = mr; v.irt = irt;
        v.bt = bt; v.busy = busy; v.e_stall = es; v.e_pcw = ep; v.e_ifw = ei;
        v.e_fl = ef; v.e_next = en;
        return v;
    endfunction

    initial begin
        logic [5:0] ops[6];
        ops[0] = c_RT; ops[1] = c_BEQ; ops[2] = c_ADI;
        ops[3] = c_LDW; ops[4] = c_STB; ops[5] = c_STW;

        //            name        op     rs  rt  mr irt bt bsy  st pcw ifw fl nxt
        vecs[0]  = mk("rtype_rs", c_RT,  3,  7, 1, 3,  0, 0,   1, 0,  0,  0, 1);
        vecs[1]  = mk("ldw_rt",   c_LDW, 5,  3, 1, 3,  0, 0,   0, 1,  1,  0, 0);
        vecs[2]  = mk("rt_zero",  c_RT,  0,  0, 1, 0,  0, 0,   0, 1,  1,  0, 0);
        vecs[3]  = mk("stw_rt",   c_STW, 1,  3, 1, 3,  0, 0,   1, 0,  0,  0, 1);
        vecs[4]  = mk("beq_rt",   c_BEQ, 2,  9, 1, 9,  0, 0,   1, 0,  0,  0, 1);
        vecs[5]  = mk("addi_rt",  c_ADI, 1,  3, 1, 3,  0, 0,   0, 1,  1,  0, 0);
        vecs[6]  = mk("br_lu",    c_RT,  3,  7, 1, 3,  1, 0,   0, 1,  1,  1, 3);
        vecs[7]  = mk("busy",     c_ADI, 1,  2, 0, 4,  0, 1,   1, 0,  0,  0, 2);
        vecs[8]  = mk("br_busy",  c_RT,  1,  2, 0, 4,  1, 1,   1, 1,  0,  1, 3);
        vecs[9]  = mk("no_load",  c_RT,  3,  3, 0, 3,  0, 0,   0, 1,  1,  0, 0);
        vecs[10] = mk("stb_rt",   c_STB, 4, 31, 1, 31, 0, 0,   1, 0,  0,  0, 1);
        vecs[11] = mk("rtype_rt", c_RT,  6, 12, 1, 12, 0, 0,   1, 0,  0,  0, 1);

        drive(c_RT, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        do_reset();

        // ---------------- vector table, each from a fresh RUN state
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].mr, vecs[i].irt,
                  vecs[i].bt, vecs[i].busy);
            do_reset();
            #2;
            check({vecs[i].name, "_comb"},
                  int'({bus.stall, bus.pc_write, bus.ifid_write, bus.flush_ifid,
                        bus.flush_idex, bus.flush_exmem}),
                  int'({vecs[i].e_stall, vecs[i].e_pcw, vecs[i].e_ifw,
                        vecs[i].e_fl, vecs[i].e_fl, vecs[i].e_fl}));
            @(posedge clk);
            #1;
            check({vecs[i].name, "_next"}, int'(bus.state), vecs[i].e_next);
        end

        // ---------------- load-use: RUN -> LDSTALL -> RUN, one stall cycle
        drive(c_RT, 0, 0, 0, 0, 0, 0);
        do_reset();
        drive(c_RT, 3, 7, 1, 3, 0, 0);
        step();
        check("lu_in_ldstall", int'(bus.state), 1);
        step();                       // same operands, masked in LDSTALL
        check("lu_back_run", int'(bus.state), 0);

        // ---------------- branch with load-use: FLUSH masks, then RUN
        drive(c_RT, 3, 7, 1, 3, 1, 0);
        step();
        check("br_flush_state", int'(bus.state), 3);
        drive(c_RT, 3, 7, 1, 3, 0, 0);
        step();
        check("flush_to_run", int'(bus.state), 0);

        // ---------------- long memory busy, timeout at the 255th cycle
        drive(c_ADI, 1, 2, 0, 0, 0, 1);
        do_reset();
        for (int i = 1; i <= 260; i++) begin
            step();
            check("busy_memwait", int'(bus.state), 2);
            check("busy_timeout", int'(bus.mem_timeout), (i >= 255) ? 1 : 0);
        end
        drive(c_ADI, 1, 2, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("timeout_sticky", int'(bus.mem_timeout), 1);
        end

        // ---------------- asynchronous reset in the middle of MEMWAIT
        drive(c_ADI, 1, 2, 0, 0, 0, 1);
        step();
        step();
        check("pre_reset_memwait", int'(bus.state), 2);
        do_reset();                  // mem_busy still high during reset
        drive(c_ADI, 1, 2, 0, 0, 0, 0);
        step();
        check("post_reset_run", int'(bus.state), 0);

        // ---------------- statistics: 10 stall cycles
        do_reset();
        drive(c_ADI, 1, 2, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step();
        drive(c_ADI, 1, 2, 0, 0, 0, 0);
        step();
`ifdef HAZARD_STATS_EN
        check("stats_10", int'(bus.stall_cycles), 10);
`else
        check("stats_off", int'(bus.stall_cycles), 0);
`endif

        // ---------------- randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(ops[$urandom_range(0, 5)],
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 6) == 0) ? 1'b1 : 1'b0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on posedge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have: ifid_opcode  in  6  opcode of the instruction in IF/ID (the instruction being decoded).
REQ-004 SHALL have: ifid_rs, ifid_rt  in  5 each  source registers of the IF/ID instruction.
REQ-005 SHALL have: idex_memread  in  1, idex_rt  in  5  load flag and load destination of the ID/EX instruction.
REQ-006 SHALL have: branch_taken  in  1  branch resolved taken in M stage; mem_busy  in  1  memory not ready.
REQ-007 SHALL have: stall  out  1  to decode control (forces bubble); pc_write, ifid_write  out  1 each  register enables.
REQ-008 SHALL have: flush_ifid, flush_idex, flush_exmem  out  1 each; state  out  2; mem_timeout  out  1  sticky.
REQ-009 SHALL have: stall_cycles  out  16, flush_count  out  8  (statistics, see Configuration).

Function
REQ-010 SHALL implement FSM states RUN=0, LDSTALL=1, MEMWAIT=2, FLUSH=3; state output equals the current state.
REQ-011 SHALL define uses_rt = ifid_opcode is OP_RTYPE, OP_STB, OP_STW or OP_BEQ (define.v codes); otherwise only rs is a source.
REQ-012 SHALL define load_use = idex_memread and idex_rt!=0 and (idex_rt==ifid_rs or (uses_rt and idex_rt==ifid_rt)).
REQ-013 SHALL drive flush_ifid=flush_idex=flush_exmem=branch_taken combinationally in the same cycle, in every state.
REQ-014 SHALL drive stall = mem_busy or (state==RUN and load_use and not branch_taken), combinationally.
REQ-015 SHALL drive pc_write = ifid_write = not stall, except pc_write=1 whenever branch_taken (target load wins).
REQ-016 Transition priority at each posedge: branch_taken -> FLUSH; else mem_busy -> MEMWAIT; else RUN with load_use -> LDSTALL; else RUN.
REQ-017 SHALL leave LDSTALL after exactly one cycle; load_use SHALL be ignored in LDSTALL (ID/EX now holds a bubble).
REQ-018 SHALL remain in MEMWAIT while mem_busy=1; on mem_busy=0 return to RUN and re-evaluate load_use in that cycle.
REQ-019 SHALL stay in FLUSH exactly one cycle, masking load_use (IF/ID is a flushed bubble), then follow REQ-016.
REQ-020 SHALL count consecutive mem_busy cycles in an 8-bit counter, cleared when mem_busy=0; at 255 set mem_timeout, held until reset.
REQ-021 branch_taken together with mem_busy: flushes SHALL assert, stall SHALL assert, next state FLUSH.

Reset
REQ-022 On reset: state=RUN, busy counter=0, mem_timeout=0, stall_cycles=0, flush_count=0.
REQ-023 While reset high, stall=0, pc_write=ifid_write=1 and flushes follow branch_taken; reset mid-MEMWAIT or mid-FLUSH SHALL return to RUN without extra cycles.

Configuration
REQ-024 Macro HAZARD_STATS_EN: when defined, stall_cycles SHALL increment (saturating at 65535) every cycle stall=1 and flush_count (saturating at 255) every cycle branch_taken=1.
REQ-025 Without HAZARD_STATS_EN, stall_cycles and flush_count SHALL be constant 0 and no counter registers SHALL be built; all other behaviour is identical.

Verification
REQ-026 LDW r3 in ID/EX (idex_memread=1, idex_rt=3), R-type rs=3 in IF/ID -> stall=1, pc_write=0 one cycle, state RUN->LDSTALL->RUN.
REQ-027 Same load, IF/ID is LDW with rs=5, rt=3 -> stall=0 (rt not a source); idex_rt=0 with rs=0 -> stall=0.
REQ-028 branch_taken one cycle concurrent with load_use -> all three flushes=1, stall=0, pc_write=1, next state FLUSH, then RUN.
REQ-029 mem_busy held 260 cycles -> stall=1 throughout, state MEMWAIT, mem_timeout=1 from the 255th busy cycle, stays 1 after mem_busy drops.
REQ-030 Reset asserted asynchronously mid-MEMWAIT -> state=0, mem_timeout=0 before next clock edge; with HAZARD_STATS_EN, 10 stall cycles -> stall_cycles=10.
